// File: rtl/game_ctrl.sv
// game_ctrl: frame-rate Pong controller (ball, paddles, BCD scores, serve/point FSM).
// Optional macro GAME_CTRL_WIN_LIMIT_EN: a score reaching 9 ends the game (OVER state).
module game_ctrl #(
  parameter logic [10:0] BALL_SIZE  = 11'd20,
  parameter logic [10:0] PAD_HEIGHT = 11'd100,
  parameter logic [10:0] PAD_WIDTH  = 11'd10,
  parameter logic [10:0] PAD_OFFS   = 11'd35,
  parameter logic [10:0] H_RES      = 11'd1280,
  parameter logic [10:0] V_RES      = 11'd800,
  parameter logic [10:0] PAD_SPEED  = 11'd8,
  parameter logic [10:0] BALL_SPEED = 11'd4,
  parameter logic [5:0]  POINT_HOLD = 6'd60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        up_l,
  input  logic        dn_l,
  input  logic        up_r,
  input  logic        dn_r,
  input  logic        serve,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [10:0] padl_y,
  output logic [10:0] padr_y,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over
);

  localparam logic [11:0] BS      = {1'b0, BALL_SIZE};
  localparam logic [11:0] BSP     = {1'b0, BALL_SPEED};
  localparam logic [11:0] PSP     = {1'b0, PAD_SPEED};
  localparam logic [11:0] PH      = {1'b0, PAD_HEIGHT};
  localparam logic [11:0] X_MAX   = {1'b0, H_RES} - BS;
  localparam logic [11:0] Y_MAX   = {1'b0, V_RES} - BS;
  localparam logic [11:0] PAD_MAX = {1'b0, V_RES} - PH;
  localparam logic [11:0] L_FACE  = {1'b0, PAD_OFFS} + {1'b0, PAD_WIDTH};
  localparam logic [11:0] R_FACE  = {1'b0, H_RES} - {1'b0, PAD_OFFS} - {1'b0, PAD_WIDTH} - 12'd1;
  localparam logic [11:0] R_STOP  = R_FACE - BS;
  localparam logic [11:0] X_MID   = X_MAX >> 1;
  localparam logic [11:0] Y_MID   = Y_MAX >> 1;
  localparam logic [11:0] PAD_MID = PAD_MAX >> 1;

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

  state_t      state;
  logic        dx;        // 1 = moving right
  logic        dy;        // 1 = moving down
  logic        serve_to;  // side that conceded last: 1 = right
  logic        pending;
  logic [5:0]  hold_cnt;

  logic [11:0] bx, by, pl, pr;
  logic [11:0] x_inc, x_dec, y_inc, y_dec;
  logic        ov_l, ov_r;
  logic [10:0] nx, ny;
  logic        ndx, ndy, miss_l, miss_r;
  logic [10:0] padl_nxt, padr_nxt;
  logic        serve_ok;

  function automatic logic [10:0] pad_step(input logic [10:0] y, input logic up, input logic dn);
    logic [11:0] dec;
    logic [11:0] inc;
    dec = {1'b0, y} - PSP;
    inc = {1'b0, y} + PSP;
    pad_step = y;
    if (up && !dn) begin
      if (dec[11]) pad_step = 11'd0;
      else         pad_step = dec[10:0];
    end else if (dn && !up) begin
      if (inc > PAD_MAX) pad_step = PAD_MAX[10:0];
      else               pad_step = inc[10:0];
    end else begin
      pad_step = y;
    end
  endfunction

  function automatic logic [3:0] bcd_inc(input logic [3:0] s);
    if (s >= 4'd9) bcd_inc = 4'd0;
    else           bcd_inc = s + 4'd1;
  endfunction

  assign bx    = {1'b0, ball_x};
  assign by    = {1'b0, ball_y};
  assign pl    = {1'b0, padl_y};
  assign pr    = {1'b0, padr_y};
  assign x_inc = bx + BSP;
  assign x_dec = bx - BSP;
  assign y_inc = by + BSP;
  assign y_dec = by - BSP;
  assign ov_l  = ((by + BS) > pl) && (by < (pl + PH));
  assign ov_r  = ((by + BS) > pr) && (by < (pr + PH));

  assign padl_nxt = pad_step(padl_y, up_l, dn_l);
  assign padr_nxt = pad_step(padr_y, up_r, dn_r);

`ifdef GAME_CTRL_WIN_LIMIT_EN
  logic win;
  assign win      = miss_l ? (score_r == 4'd8) : (score_l == 4'd8);
  assign serve_ok = (state == S_SERVE) || (state == S_OVER);
`else
  assign serve_ok = (state == S_SERVE);
`endif

  // Next ball position: wall, paddle and miss clamps judged on pre-move values.
  always_comb begin
    nx     = ball_x;
    ny     = ball_y;
    ndx    = dx;
    ndy    = dy;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (dy) begin
      if (y_inc >= Y_MAX) begin
        ny  = Y_MAX[10:0];
        ndy = 1'b0;
      end else begin
        ny  = y_inc[10:0];
      end
    end else begin
      if (y_dec[11] || (y_dec == 12'd0)) begin
        ny  = 11'd0;
        ndy = 1'b1;
      end else begin
        ny  = y_dec[10:0];
      end
    end
    if (dx) begin
      if (x_inc >= X_MAX) begin
        nx     = X_MAX[10:0];
        miss_r = 1'b1;
      end else if (((x_inc + BS) >= R_FACE) && ov_r) begin
        nx  = R_STOP[10:0];
        ndx = 1'b0;
      end else begin
        nx  = x_inc[10:0];
      end
    end else begin
      if (x_dec[11] || (x_dec == 12'd0)) begin
        nx     = 11'd0;
        miss_l = 1'b1;
      end else if ((x_dec <= L_FACE) && ov_l) begin
        nx  = L_FACE[10:0];
        ndx = 1'b1;
      end else begin
        nx  = x_dec[10:0];
      end
    end
  end

  // Game FSM and all output registers; state only advances on frame_tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SERVE;
      ball_x    <= X_MID[10:0];
      ball_y    <= Y_MID[10:0];
      padl_y    <= PAD_MID[10:0];
      padr_y    <= PAD_MID[10:0];
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      game_over <= 1'b0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      serve_to  <= 1'b1;
      pending   <= 1'b0;
      hold_cnt  <= 6'd0;
    end else if (frame_tick) begin
      case (state)
        S_SERVE: begin
          padl_y <= padl_nxt;
          padr_y <= padr_nxt;
          if (pending || serve) begin
            pending <= 1'b0;
            dx      <= serve_to;
            dy      <= 1'b1;
            state   <= S_PLAY;
          end
        end
        S_PLAY: begin
          padl_y <= padl_nxt;
          padr_y <= padr_nxt;
          ball_x <= nx;
          ball_y <= ny;
          dx     <= ndx;
          dy     <= ndy;
          if (miss_l || miss_r) begin
            serve_to <= miss_r;
            hold_cnt <= 6'd0;
            if (miss_l) score_r <= bcd_inc(score_r);
            else        score_l <= bcd_inc(score_l);
`ifdef GAME_CTRL_WIN_LIMIT_EN
            if (win) begin
              state     <= S_OVER;
              game_over <= 1'b1;
            end else begin
              state     <= S_POINT;
            end
`else
            state <= S_POINT;
`endif
          end
        end
        S_POINT: begin
          if (hold_cnt == (POINT_HOLD - 6'd1)) begin
            hold_cnt <= 6'd0;
            pending  <= 1'b0;
            ball_x   <= X_MID[10:0];
            ball_y   <= Y_MID[10:0];
            state    <= S_SERVE;
          end else begin
            hold_cnt <= hold_cnt + 6'd1;
          end
        end
        S_OVER: begin
`ifdef GAME_CTRL_WIN_LIMIT_EN
          if (pending || serve) begin
            pending   <= 1'b0;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            game_over <= 1'b0;
            ball_x    <= X_MID[10:0];
            ball_y    <= Y_MID[10:0];
            state     <= S_SERVE;
          end
`else
          state <= S_SERVE;
`endif
        end
        default: state <= S_SERVE;
      endcase
    end else if (serve && serve_ok) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BALL_SIZE, 11'd20, ball edge length in pixels.
- PAD_HEIGHT, 11'd100, paddle height.
- PAD_WIDTH, 11'd10, paddle width.
- PAD_OFFS, 11'd35, paddle offset from the screen edge.
- H_RES, 11'd1280, horizontal resolution.
- V_RES, 11'd800, vertical resolution.
- PAD_SPEED, 11'd8, paddle step per frame.
- BALL_SPEED, 11'd4, ball step per axis per frame.
- POINT_HOLD, 6'd60, frames frozen after a point.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst, in, 1, reset: synchronous, active-high.
- frame_tick, in, 1, one-cycle pulse once per frame at the start of vertical blank.
- up_l / dn_l / up_r / dn_r, in, 1 each, paddle buttons, already debounced and synchronised.
- serve, in, 1, serve request.
- ball_x / ball_y, out, 11, ball top-left corner.
- padl_y / padr_y, out, 11, paddle top edges.
- score_l / score_r, out, 4, BCD 0-9.
- game_over, out, 1, game finished.
REQ-003 All outputs SHALL be registered and feed the pixel painter directly, with no combinational path from inputs to outputs.

Function
REQ-004 All position, score and state updates SHALL occur only in the cycle where frame_tick=1; outputs SHALL be stable for the rest of the frame.
REQ-005 The FSM SHALL have states SERVE, PLAY, POINT, OVER; reset enters SERVE.
REQ-006 In SERVE, the ball SHALL sit at (630,390), i.e. ((H_RES-BALL_SIZE)/2, (V_RES-BALL_SIZE)/2).
REQ-007 A serve pulse in any cycle of SERVE SHALL set a pending flag; the next frame_tick SHALL clear the flag and enter PLAY, with dy=down and dx toward the player who conceded the last point (right after reset).
REQ-008 Paddles SHALL move in SERVE and PLAY only, as follows:
- up alone: y = max(y-PAD_SPEED, 0).
- dn alone: y = min(y+PAD_SPEED, V_RES-PAD_HEIGHT=700).
- both or neither: hold.
REQ-009 In PLAY, on each tick the ball SHALL move BALL_SPEED on each axis according to direction bits dx/dy, with clamps evaluated before the move is applied.
REQ-010 Wall clamps SHALL be:
- moving up with ball_y<=BALL_SPEED: ball_y=0, dy flips.
- moving down with ball_y+BALL_SPEED>=780: ball_y=780, dy flips.
REQ-011 Left paddle:
- Trigger: moving left with ball_x-BALL_SPEED<=45 (PAD_OFFS+PAD_WIDTH).
- Overlap is ball_y+BALL_SIZE>padl_y and ball_y<padl_y+PAD_HEIGHT, using the pre-update paddle value.
- With overlap: ball_x=45, dx flips.
- Without overlap: movement continues.
REQ-012 Right paddle:
- Trigger: moving right with ball_x+BALL_SPEED+BALL_SIZE>=1234 (H_RES-PAD_OFFS-PAD_WIDTH-1).
- Overlap test is the same as REQ-011, applied to padr_y.
- With overlap: ball_x=1214, dx flips.
REQ-013 Miss: moving left with ball_x<=BALL_SPEED, or moving right with ball_x+BALL_SPEED>=1260 (H_RES-BALL_SIZE), SHALL do the following:
- Clamp ball_x to 0 or 1260.
- Increment the opposing score (BCD).
- Record the conceding side.
- Enter POINT.
REQ-014 A wall hit and a paddle hit on the same tick SHALL both be applied (corner bounce).
REQ-015 POINT SHALL freeze the ball and paddles for POINT_HOLD ticks, then enter SERVE; a serve received during POINT SHALL be ignored.
REQ-016 All coordinate arithmetic SHALL be 12-bit internally so that underflow and overflow are detected before truncation to 11 bits.

Reset
REQ-017 When rst=1 at a clock edge, regardless of state or frame_tick, the following SHALL hold on the next cycle:
- ball = (630,390), padl_y = padr_y = 350.
- score_l = score_r = 0, game_over = 0.
- serve_to = right, pending flag clear, hold counter = 0.
- state = SERVE.

Configuration
REQ-018 With macro GAME_CTRL_WIN_LIMIT_EN defined, a score reaching 9 SHALL enter OVER instead of POINT. In OVER:
- game_over=1 and all positions freeze.
- A serve then SHALL clear both scores and game_over and enter SERVE.
REQ-019 Without GAME_CTRL_WIN_LIMIT_EN, OVER SHALL be unreachable, game_over SHALL be tied 0, and a score SHALL wrap from 9 to 0.

Verification
REQ-020 Reset, then 3 ticks with no input -> ball (630,390), paddles 350, scores 0, state SERVE.
REQ-021 Serve, then 1 tick -> state PLAY; on the next tick ball = (634,394).
REQ-022 Hold up_l for 50 ticks from 350 -> padl_y reaches 0 after 44 ticks and stays 0; up_l with dn_l together -> no change.
REQ-023 Ball at (48,300) moving left, padl_y=250 -> next tick ball_x=45 and dx=right; same stimulus with padl_y=500 -> ball_x=44 and, 11 ticks later, score_r=1 and state POINT.
REQ-024 In POINT, count 60 ticks -> state SERVE with ball centred; serve -> ball moves toward the right side.
REQ-025 With GAME_CTRL_WIN_LIMIT_EN, score_l at 8 and a right miss -> score_l=9, game_over=1; serve then tick -> scores 0, game_over=0; rst asserted mid-PLAY -> REQ-017 values on the next cycle.
